dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the MIPS core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs little-endian byte, half-word or word accesses on an internal word array, and returns read data, sign- or zero-extended, on a response handshake. It replaces the zero-latency data memory when the core is moved to a stall-capable memory interface.

---
 rtl/dmem_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle little-endian data-memory responder with valid/ready
//            request/response handshakes and programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================

module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_depth     = 2 ** ADDR_W;
    localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              w_accept;
    logic              w_exec;
    logic              w_wait_done;

    logic [ADDR_W+1:0] r_addr;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wait_cnt;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0]       r_mem [c_depth];

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic [4:0]        w_shamt;
    logic              w_err;
    logic [31:0]       w_word;
    logic [31:0]       w_word_sh;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_sh;
    logic              w_mem_we;

    // Address bits above the array index only alias and are deliberately dropped.
    logic              w_unused_addr;
    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_wait_done = (r_wait_cnt == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_EXEC;
                end
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture and wait-state counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_wdata    <= '0;
            r_wait_cnt <= 4'd0;
        end else begin
            if (w_accept) begin
                r_addr     <= req_addr[ADDR_W+1:0];
                r_write    <= req_write;
                r_size     <= req_size;
                r_signed   <= req_signed;
                r_wdata    <= req_wdata;
                r_wait_cnt <= c_wait_load;
            end else if (r_state == S_WAIT && !w_wait_done) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Access decode: alignment, lane select and extension
    // ------------------------------------------------------------------------
    assign w_idx   = r_addr[ADDR_W+1:2];
    assign w_lane  = r_addr[1:0];
    assign w_shamt = {w_lane, 3'b000};

    always_comb begin
        w_err = 1'b0;
        case (r_size)
            c_size_byte: w_err = 1'b0;
            c_size_half: w_err = w_lane[0];
            c_size_word: w_err = (w_lane != 2'b00);
            default:     w_err = 1'b1;
        endcase
    end

    assign w_word    = r_mem[w_idx];
    assign w_word_sh = w_word >> w_shamt;

    always_comb begin
        w_load = '0;
        case (r_size)
            c_size_byte: w_load = {{24{r_signed & w_word_sh[7]}},  w_word_sh[7:0]};
            c_size_half: w_load = {{16{r_signed & w_word_sh[15]}}, w_word_sh[15:0]};
            c_size_word: w_load = w_word_sh;
            default:     w_load = '0;
        endcase
    end

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            c_size_byte: w_be = 4'b0001 << w_lane;
            c_size_half: w_be = 4'b0011 << w_lane;
            c_size_word: w_be = 4'b1111;
            default:     w_be = 4'b0000;
        endcase
    end

    // Bits shifted past the addressed lanes are discarded by the byte enables.
    assign w_wdata_sh = r_wdata << w_shamt;
    assign w_mem_we   = w_exec && r_write && !w_err;

    // ------------------------------------------------------------------------
    // Storage (contents are intentionally not reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response registers, held through RESP backpressure
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_exec) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_write) ? 32'd0 : w_load;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (WAIT_STATES=2).
// Revision : 1.0 - initial release
// ============================================================================

module tb_dmem_responder;

    localparam int c_addr_w = 10;
    localparam int c_ws     = 2;
    localparam int c_tmo    = 40;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests;
    int n_fail;

    dmem_responder #(
        .ADDR_W      (c_addr_w),
        .WAIT_STATES (c_ws)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the cycle
    // following the response handshake. lat counts cycles from acceptance edge.
    task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output logic post_ok);
        drive_req(wr, sz, sg, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < c_tmo) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            n_tests++; n_fail++;
            $display("FAIL timeout addr=%h: no rsp_valid within %0d cycles", addr, c_tmo);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        post_ok = !rsp_valid && req_ready;
    endtask

    task automatic test_reset;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    endtask

    task automatic test_word_roundtrip;
        logic [31:0] d; logic e; int lat; logic ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, d, e, lat, ok);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL store_latency got=%0d exp=4", lat); end
        n_tests++; if (e !== 1'b0 || d !== 32'd0) begin n_fail++; $display("FAIL store_rsp got err=%b data=%h exp err=0 data=0", e, d); end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL post_handshake got=%b exp=1", ok); end
        do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL word_load got=%h err=%b exp=deadbeef err=0", d, e); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d; logic e; int lat; logic ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, d, e, lat, ok);
        do_access(1'b1, 2'b00, 1'b0, 32'h41, 32'hFFFFFF80, d, e, lat, ok);
        do_access(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_signed got=%h exp=ffffff80", d); end
        do_access(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h00000080) begin n_fail++; $display("FAIL byte_unsigned got=%h exp=00000080", d); end
        do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h00008000) begin n_fail++; $display("FAIL byte_word_view got=%h exp=00008000", d); end
    endtask

    task automatic test_half;
        logic [31:0] d; logic e; int lat; logic ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFFFFFF, d, e, lat, ok);
        do_access(1'b1, 2'b01, 1'b0, 32'h42, 32'hABCD1234, d, e, lat, ok);
        do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h1234FFFF) begin n_fail++; $display("FAIL half_word_view got=%h exp=1234ffff", d); end
        do_access(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h00001234) begin n_fail++; $display("FAIL half_signed_pos got=%h exp=00001234", d); end
        do_access(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL half_signed_neg got=%h exp=ffffffff", d); end
        do_access(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h0000FFFF) begin n_fail++; $display("FAIL half_unsigned got=%h exp=0000ffff", d); end
        do_access(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h00000012) begin n_fail++; $display("FAIL byte_lane3 got=%h exp=00000012", d); end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e; int lat; logic ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h44, 32'h11223344, d, e, lat, ok);
        do_access(1'b1, 2'b10, 1'b0, 32'h45, 32'hCAFEF00D, d, e, lat, ok);
        n_tests++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL misaligned_word got err=%b data=%h exp err=1 data=0", e, d); end
        do_access(1'b1, 2'b11, 1'b0, 32'h44, 32'h55555555, d, e, lat, ok);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_size_store got err=%b exp=1", e); end
        do_access(1'b0, 2'b01, 1'b1, 32'h45, 32'h0, d, e, lat, ok);
        n_tests++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL misaligned_half got err=%b data=%h exp err=1 data=0", e, d); end
        do_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h11223344 || e !== 1'b0) begin n_fail++; $display("FAIL error_no_write got=%h err=%b exp=11223344 err=0", d, e); end
        do_access(1'b0, 2'b11, 1'b0, 32'h44, 32'h0, d, e, lat, ok);
        n_tests++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL illegal_size_load got err=%b data=%h exp err=1 data=0", e, d); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic e; int lat; logic ok; int cyc;
        drive_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;   // ignored outside RESP
        cyc = 0;
        while (!rsp_valid && cyc < c_tmo) begin
            @(posedge clk); #1;
            cyc++;
            rsp_ready = 1'b0;
        end
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got rsp_valid=%b exp=1", rsp_valid); end
        // A competing store is presented while stalled and must be ignored.
        drive_req(1'b1, 2'b10, 1'b0, 32'h44, 32'h99999999);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11223344 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b exp valid=1 data=11223344 ready=0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h11223344) begin n_fail++; $display("FAIL bp_ignored_req got=%h exp=11223344", d); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [31:0] d; logic e; int lat; logic ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h48, 32'h0BADF00D, d, e, lat, ok);
        drive_req(1'b1, 2'b10, 1'b0, 32'h48, 32'hFEEDC0DE);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < c_tmo) begin
            @(posedge clk); #1;
            cyc++;
        end
        // Present the next request so it lands at the earliest legal edge.
        drive_req(1'b0, 2'b10, 1'b0, 32'h48, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < c_tmo) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++; if (cyc !== 4 || rsp_rdata !== 32'hFEEDC0DE) begin n_fail++; $display("FAIL b2b_load got lat=%0d data=%h exp lat=4 data=feedc0de", cyc, rsp_rdata); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_alias;
        logic [31:0] d; logic e; int lat; logic ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h1000, 32'h5A5A1234, d, e, lat, ok);
        do_access(1'b0, 2'b10, 1'b0, 32'h0000, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h5A5A1234) begin n_fail++; $display("FAIL alias got=%h exp=5a5a1234", d); end
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] d; logic e; int lat; logic ok;
        do_access(1'b1, 2'b10, 1'b0, 32'h80, 32'h01020304, d, e, lat, ok);
        do_access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, d, e, lat, ok);
        drive_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hAAAAAAAA);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy got ready=%b exp=0", req_ready); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got ready=%b valid=%b data=%h err=%b exp 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_access(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, d, e, lat, ok);
        n_tests++; if (d !== 32'h01020304) begin n_fail++; $display("FAIL reset_no_commit got=%h exp=01020304", d); end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_word_roundtrip();
        test_byte_lanes();
        test_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_alias();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
